// File: rtl/prog_mem_if.sv
// Program-fetch and loader bus between a CPU/loader (master) and prog_mem_responder (slave).
interface prog_mem_if #(
    parameter int unsigned ADDR_WIDTH = 12
) ();
    logic                  rd_req;
    logic [15:0]           rd_addr;
    logic [7:0]            rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic                  load_mode;
    logic                  load_valid;
    logic [7:0]            load_data;
    logic                  load_ready;
    logic [ADDR_WIDTH-1:0] load_count;

    modport master (
        output rd_req, rd_addr, load_mode, load_valid, load_data,
        input  rd_data, rd_valid, busy, load_ready, load_count
    );

    modport slave (
        input  rd_req, rd_addr, load_mode, load_valid, load_data,
        output rd_data, rd_valid, busy, load_ready, load_count
    );
endinterface

// File: rtl/prog_mem_responder.sv
// Program byte memory answering CPU reads after WAIT_STATES extra cycles, with a byte-stream load port.
// Optional background next-address prefetch buffer: define PROG_MEM_PREFETCH_EN.
module prog_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    prog_mem_if.slave  bus
);
    localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_LOAD
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  busy_q, busy_d;
    logic                  load_ready_q, load_ready_d;
    logic [ADDR_WIDTH-1:0] load_count_q, load_count_d;

    logic [7:0]            mem [MEM_DEPTH];
    logic [7:0]            mem_rd_q;
    logic                  rd_en_c;
    logic [ADDR_WIDTH-1:0] rd_ptr_c;
    logic                  wr_en_c;
    logic [ADDR_WIDTH-1:0] req_addr_c;

    assign req_addr_c = bus.rd_addr[ADDR_WIDTH-1:0];

    if (ADDR_WIDTH < 16) begin : g_unused
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.rd_addr[15:ADDR_WIDTH];
    end

`ifdef PROG_MEM_PREFETCH_EN
    logic                  pf_busy_q, pf_busy_d;
    logic                  pf_valid_q, pf_valid_d;
    logic [CNT_W-1:0]      pf_cnt_q, pf_cnt_d;
    logic [ADDR_WIDTH-1:0] pf_addr_q, pf_addr_d;
`endif

    // Single read port shared by the main path and the prefetcher; mem_rd_q doubles as the prefetch buffer.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[load_count_q] <= bus.load_data;
        if (rd_en_c) mem_rd_q <= mem[rd_ptr_c];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b0;
            load_count_q <= '0;
`ifdef PROG_MEM_PREFETCH_EN
            pf_busy_q    <= 1'b0;
            pf_valid_q   <= 1'b0;
            pf_cnt_q     <= '0;
            pf_addr_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            load_ready_q <= load_ready_d;
            load_count_q <= load_count_d;
`ifdef PROG_MEM_PREFETCH_EN
            pf_busy_q    <= pf_busy_d;
            pf_valid_q   <= pf_valid_d;
            pf_cnt_q     <= pf_cnt_d;
            pf_addr_q    <= pf_addr_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        load_count_d = load_count_q;
        rd_en_c      = 1'b0;
        rd_ptr_c     = addr_q;
        wr_en_c      = 1'b0;
`ifdef PROG_MEM_PREFETCH_EN
        pf_busy_d    = pf_busy_q;
        pf_valid_d   = pf_valid_q;
        pf_cnt_d     = pf_cnt_q;
        pf_addr_d    = pf_addr_q;

        // Background fetch runs only while the FSM idles; requests below cancel it.
        if (pf_busy_q) begin
            if (pf_cnt_q == '0) begin
                rd_en_c    = 1'b1;
                rd_ptr_c   = pf_addr_q;
                pf_busy_d  = 1'b0;
                pf_valid_d = 1'b1;
            end else begin
                pf_cnt_d = pf_cnt_q - 1'b1;
            end
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_mode) begin
                    state_d      = S_LOAD;
                    load_count_d = '0;
`ifdef PROG_MEM_PREFETCH_EN
                    pf_busy_d    = 1'b0;
                    pf_valid_d   = 1'b0;
`endif
                end else if (bus.rd_req) begin
                    addr_d = req_addr_c;
`ifdef PROG_MEM_PREFETCH_EN
                    pf_busy_d  = 1'b0;
                    pf_valid_d = 1'b0;
                    if (pf_valid_q && (req_addr_c == pf_addr_q)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
`else
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(WAIT_STATES);
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    rd_en_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_rd_q;
                state_d    = S_IDLE;
`ifdef PROG_MEM_PREFETCH_EN
                pf_busy_d  = 1'b1;
                pf_valid_d = 1'b0;
                pf_cnt_d   = CNT_W'(WAIT_STATES);
                pf_addr_d  = ADDR_WIDTH'(addr_q + 1'b1);
`endif
            end
            S_LOAD: begin
                if (bus.load_valid) begin
                    wr_en_c      = 1'b1;
                    load_count_d = ADDR_WIDTH'(load_count_q + 1'b1);
                end
                if (!bus.load_mode) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d != S_IDLE);
        load_ready_d = (state_d == S_LOAD);
    end

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.busy       = busy_q;
    assign bus.load_ready = load_ready_q;
    assign bus.load_count = load_count_q;
endmodule

// File: tb/tb_prog_mem_responder.sv
// Scoreboard bench for prog_mem_responder: reads push expected data/cycle, a monitor checks each rd_valid.
module tb_prog_mem_responder;
    localparam int unsigned AW   = 12;
    localparam int unsigned WS   = 1;
    localparam int unsigned NORM = 2 + WS;

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];

    prog_mem_if #(.ADDR_WIDTH(AW)) bus ();

    prog_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got data %0h with no read outstanding (cycle %0d)",
                         bus.rd_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(e.data));
                check("rd_latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns just after the sampling edge.
    task automatic issue_read(input logic [15:0] a, input logic [7:0] d, input int unsigned lat);
        exp_t e;
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        @(posedge clk);
        #1;
        e.data = d;
        e.cyc  = cyc + lat;
        exp_q.push_back(e);
        bus.rd_req = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [15:0] rd_addrs [3] = '{16'h0001, 16'h0000, 16'h0002};
    logic [7:0]  rd_exps  [3] = '{8'h0F, 8'h31, 8'hE6};
    logic [7:0]  ld_bytes [3] = '{8'h31, 8'h0F, 8'hE6};

    initial begin
        reset_n        = 1'b0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.load_mode  = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_after_reset", {28'd0, bus.rd_valid, bus.busy, bus.load_ready, |bus.load_count}, 32'd0);
        end
        check("rd_data_reset", 32'(bus.rd_data), 32'h00);

        // Load three bytes with load_valid held high
        bus.load_mode = 1'b1;
        @(negedge clk);
        check("load_ready_entry", 32'(bus.load_ready), 32'd1);
        check("load_count_entry", 32'(bus.load_count), 32'd0);
        bus.load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.load_data = ld_bytes[i];
            @(negedge clk);
            check("load_count", 32'(bus.load_count), 32'(i + 1));
        end
        bus.load_valid = 1'b0;
        bus.load_mode  = 1'b0;
        @(negedge clk);
        check("load_exit_ready", 32'(bus.load_ready), 32'd0);
        check("load_exit_busy", 32'(bus.busy), 32'd0);
        check("load_count_hold", 32'(bus.load_count), 32'd3);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue_read(rd_addrs[i], rd_exps[i], NORM);
            wait_drain();
        end

        // Second request while busy must be dropped
        @(negedge clk);
        issue_read(16'h0002, 8'hE6, NORM);
        @(negedge clk);
        check("busy_in_wait", 32'(bus.busy), 32'd1);
        bus.rd_addr = 16'h0000;
        bus.rd_req  = 1'b1;
        @(negedge clk);
        bus.rd_req  = 1'b0;
        wait_drain();
        repeat (6) @(negedge clk);

        @(negedge clk);
        issue_read(16'h1001, 8'h0F, NORM);
        wait_drain();

        // Reset while in WAIT aborts the read
        @(negedge clk);
        bus.rd_addr = 16'h0000;
        bus.rd_req  = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_mid_wait_busy", 32'(bus.busy), 32'd0);
        check("reset_mid_wait_valid", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("after_abort_idle", {30'd0, bus.rd_valid, bus.busy}, 32'd0);
        end
        @(negedge clk);
        issue_read(16'h0000, 8'h31, NORM);
        wait_drain();

`ifdef PROG_MEM_PREFETCH_EN
        @(negedge clk);
        issue_read(16'h0000, 8'h31, NORM);
        wait_drain();
        repeat (4) @(negedge clk);
        issue_read(16'h0001, 8'h0F, 1);
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (bus.rd_valid !== 1'b1 && t < 20);
        end
        issue_read(16'h0002, 8'hE6, NORM);
        wait_drain();
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
